// File: rtl/vision_pkg.sv
// -----------------------------------------------------------------------------
// vision_pkg
// Shared constants and types for the vision pipeline blocks.
//   - Default image geometry (DEF_IMG_WIDTH / DEF_IMG_HEIGHT)
//   - Default coordinate / counter / sum widths
//   - Minimum foreground pixel count for a valid target
//   - Target-locator FSM state encoding
// -----------------------------------------------------------------------------
package vision_pkg;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int DEF_X_W        = 10;
  localparam int DEF_Y_W        = 9;
  localparam int DEF_CNT_W      = 19;
  localparam int DEF_SUM_W      = 29;   // DEF_CNT_W + DEF_X_W
  localparam int DEF_MIN_PIXELS = 64;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIVIDE = 2'd1,
    OUTPUT = 2'd2
  } loc_state_e;

endpackage

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Restoring sequential unsigned divider, one quotient bit per clock.
// The start cycle already performs the first iteration, so N_W iterations
// complete N_W-1 cycles after start; done pulses in the cycle after the last
// iteration and the quotient then holds until the next start.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start          1-cycle request; dividend/divisor are sampled this cycle
//   dividend       N_W-bit numerator
//   divisor        D_W-bit denominator (must be non-zero)
//   done           1-cycle completion pulse
//   quotient       low Q_W bits of the quotient
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int N_W = 29,
  parameter int D_W = 19,
  parameter int Q_W = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           done,
  output logic [Q_W-1:0] quotient
);

  localparam int C_W = $clog2(N_W + 1);
  localparam logic [C_W-1:0] C_LOAD = C_W'(N_W - 1);
  localparam logic [C_W-1:0] C_ONE  = C_W'(1);

  logic [D_W-1:0] r_rem;
  logic [N_W-1:0] r_quo;
  logic [D_W-1:0] r_div;
  logic [C_W-1:0] r_cnt;
  logic           r_busy;
  logic           r_done;

  logic [D_W-1:0] w_src_rem;
  logic [N_W-1:0] w_src_quo;
  logic [D_W-1:0] w_src_div;
  logic [D_W:0]   w_shift;
  logic           w_ge;
  logic [D_W-1:0] w_rem_next;
  logic [N_W-1:0] w_quo_next;

  // One restoring step; on start the step works on the fresh operands.
  always_comb begin
    w_src_rem  = start ? {D_W{1'b0}} : r_rem;
    w_src_quo  = start ? dividend : r_quo;
    w_src_div  = start ? divisor : r_div;
    w_shift    = {w_src_rem, w_src_quo[N_W-1]};
    w_ge       = (w_shift >= {1'b0, w_src_div});
    // When w_ge the true difference is below the divisor, so D_W bits suffice.
    if (w_ge) begin
      w_rem_next = w_shift[D_W-1:0] - w_src_div;
    end else begin
      w_rem_next = w_shift[D_W-1:0];
    end
    w_quo_next = {w_src_quo[N_W-2:0], w_ge};
  end

  // Iteration state, iteration counter and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= {D_W{1'b0}};
      r_quo  <= {N_W{1'b0}};
      r_div  <= {D_W{1'b0}};
      r_cnt  <= {C_W{1'b0}};
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_rem  <= w_rem_next;
        r_quo  <= w_quo_next;
        r_div  <= divisor;
        r_cnt  <= C_LOAD;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
        r_cnt <= r_cnt - C_ONE;
        if (r_cnt == C_ONE) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done     = r_done;
  assign quotient = r_quo[Q_W-1:0];

endmodule

// File: rtl/binary_target_locator.sv
// -----------------------------------------------------------------------------
// binary_target_locator
// Accumulates foreground pixel count and x/y coordinate sums over each frame of
// a thresholded binary pixel stream, then divides to obtain the target
// centroid. One result_valid pulse per accepted frame.
// Optional bounding box: define BINARY_LOCATOR_BBOX_EN to build min/max x/y
// tracking; otherwise the bbox_* outputs are tied to 0.
// Ports:
//   clk, rst            pixel clock, asynchronous active-high reset
//   vsync_in            frame sync (high = vertical blanking)
//   href_in             line valid, one pixel per clock
//   binary_data_in      32-bit binary pixel word (all ones / all zeros)
//   result_valid        1-cycle pulse, outputs below valid from this cycle
//   target_found        pixel_count >= MIN_PIXELS
//   target_x/target_y   centroid coordinates
//   pixel_count         foreground pixels in the frame
//   frame_drop          1-cycle pulse when a frame result is discarded
//   bbox_min/max_x/y    bounding box of the foreground pixels
// -----------------------------------------------------------------------------
module binary_target_locator
  import vision_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int SUM_W      = DEF_SUM_W,
  parameter int MIN_PIXELS = DEF_MIN_PIXELS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync_in,
  input  logic             href_in,
  input  logic [31:0]      binary_data_in,
  output logic             result_valid,
  output logic             target_found,
  output logic [X_W-1:0]   target_x,
  output logic [Y_W-1:0]   target_y,
  output logic [CNT_W-1:0] pixel_count,
  output logic             frame_drop,
  output logic [X_W-1:0]   bbox_min_x,
  output logic [X_W-1:0]   bbox_max_x,
  output logic [Y_W-1:0]   bbox_min_y,
  output logic [Y_W-1:0]   bbox_max_y
);

  // Coordinate counters carry one extra bit so they can sit at IMG_WIDTH/HEIGHT.
  localparam logic [X_W:0]     C_XMAX    = (X_W + 1)'(IMG_WIDTH);
  localparam logic [Y_W:0]     C_YMAX    = (Y_W + 1)'(IMG_HEIGHT);
  localparam logic [X_W:0]     C_X_ONE   = (X_W + 1)'(1);
  localparam logic [Y_W:0]     C_Y_ONE   = (Y_W + 1)'(1);
  localparam logic [CNT_W-1:0] C_MIN     = CNT_W'(MIN_PIXELS);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  loc_state_e       r_state;
  loc_state_e       w_next_state;
  logic             r_vsync;
  logic             r_href;
  logic [X_W:0]     r_x;
  logic [Y_W:0]     r_y;
  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] r_sum_x;
  logic [SUM_W-1:0] r_sum_y;
  logic [CNT_W-1:0] r_lat_cnt;
  logic             r_lat_found;

  logic             w_frame_end;
  logic             w_fg;
  logic             w_enough;
  logic             w_start;
  logic             w_drop;
  logic             w_done_x;
  logic             w_done_y;
  logic [X_W-1:0]   w_qx;
  logic [Y_W-1:0]   w_qy;

  assign w_frame_end = vsync_in & ~r_vsync;
  assign w_fg        = href_in & ~vsync_in & (|binary_data_in)
                     & (r_x < C_XMAX) & (r_y < C_YMAX);
  assign w_enough    = (r_cnt >= C_MIN);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, divider start and drop detection.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      ACCUM: begin
        if (w_frame_end) begin
          if (w_enough) begin
            w_start      = 1'b1;
            w_next_state = DIVIDE;
          end else begin
            w_next_state = OUTPUT;
          end
        end else begin
          w_next_state = ACCUM;
        end
      end
      DIVIDE: begin
        w_drop = w_frame_end;
        if (w_done_x && w_done_y) begin
          w_next_state = OUTPUT;
        end else begin
          w_next_state = DIVIDE;
        end
      end
      OUTPUT: begin
        w_drop       = w_frame_end;
        w_next_state = ACCUM;
      end
      default: begin
        w_drop       = w_frame_end;
        w_next_state = ACCUM;
      end
    endcase
  end

  // Sync edge detection and pixel coordinate counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_x     <= {(X_W + 1){1'b0}};
      r_y     <= {(Y_W + 1){1'b0}};
    end else begin
      r_vsync <= vsync_in;
      r_href  <= href_in;
      if (href_in) begin
        if (r_x < C_XMAX) begin
          r_x <= r_x + C_X_ONE;
        end
      end else begin
        r_x <= {(X_W + 1){1'b0}};
      end
      if (w_frame_end) begin
        r_y <= {(Y_W + 1){1'b0}};
      end else if (r_href && !href_in && (r_y < C_YMAX)) begin
        r_y <= r_y + C_Y_ONE;
      end
    end
  end

  // Per-frame accumulators; the result is latched only if the FSM can take it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= {CNT_W{1'b0}};
      r_sum_x     <= {SUM_W{1'b0}};
      r_sum_y     <= {SUM_W{1'b0}};
      r_lat_cnt   <= {CNT_W{1'b0}};
      r_lat_found <= 1'b0;
    end else if (w_frame_end) begin
      r_cnt   <= {CNT_W{1'b0}};
      r_sum_x <= {SUM_W{1'b0}};
      r_sum_y <= {SUM_W{1'b0}};
      if (r_state == ACCUM) begin
        r_lat_cnt   <= r_cnt;
        r_lat_found <= w_enough;
      end
    end else if (w_fg) begin
      r_cnt   <= r_cnt + C_CNT_ONE;
      r_sum_x <= r_sum_x + SUM_W'(r_x);
      r_sum_y <= r_sum_y + SUM_W'(r_y);
    end
  end

  // Operands are taken straight from the accumulators on the frame-end cycle.
  seq_divider #(
    .N_W (SUM_W),
    .D_W (CNT_W),
    .Q_W (X_W)
  ) u_div_x (
    .clk      (clk),
    .rst      (rst),
    .start    (w_start),
    .dividend (r_sum_x),
    .divisor  (r_cnt),
    .done     (w_done_x),
    .quotient (w_qx)
  );

  seq_divider #(
    .N_W (SUM_W),
    .D_W (CNT_W),
    .Q_W (Y_W)
  ) u_div_y (
    .clk      (clk),
    .rst      (rst),
    .start    (w_start),
    .dividend (r_sum_y),
    .divisor  (r_cnt),
    .done     (w_done_y),
    .quotient (w_qy)
  );

  // Result registers, loaded while in OUTPUT and held until the next result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_valid <= 1'b0;
      frame_drop   <= 1'b0;
      target_found <= 1'b0;
      target_x     <= {X_W{1'b0}};
      target_y     <= {Y_W{1'b0}};
      pixel_count  <= {CNT_W{1'b0}};
    end else begin
      result_valid <= 1'b0;
      frame_drop   <= w_drop;
      if (r_state == OUTPUT) begin
        result_valid <= 1'b1;
        target_found <= r_lat_found;
        pixel_count  <= r_lat_cnt;
        if (r_lat_found) begin
          target_x <= w_qx;
          target_y <= w_qy;
        end else begin
          target_x <= {X_W{1'b0}};
          target_y <= {Y_W{1'b0}};
        end
      end
    end
  end

`ifdef BINARY_LOCATOR_BBOX_EN
  logic [X_W-1:0] r_min_x;
  logic [X_W-1:0] r_max_x;
  logic [Y_W-1:0] r_min_y;
  logic [Y_W-1:0] r_max_y;
  logic [X_W-1:0] r_lat_min_x;
  logic [X_W-1:0] r_lat_max_x;
  logic [Y_W-1:0] r_lat_min_y;
  logic [Y_W-1:0] r_lat_max_y;
  logic [X_W-1:0] w_px;
  logic [Y_W-1:0] w_py;

  // Foreground pixels always lie inside the image, so the low bits are exact.
  assign w_px = r_x[X_W-1:0];
  assign w_py = r_y[Y_W-1:0];

  // Running min/max per frame, latched with the frame result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min_x     <= {X_W{1'b1}};
      r_max_x     <= {X_W{1'b0}};
      r_min_y     <= {Y_W{1'b1}};
      r_max_y     <= {Y_W{1'b0}};
      r_lat_min_x <= {X_W{1'b0}};
      r_lat_max_x <= {X_W{1'b0}};
      r_lat_min_y <= {Y_W{1'b0}};
      r_lat_max_y <= {Y_W{1'b0}};
    end else if (w_frame_end) begin
      if (r_state == ACCUM) begin
        r_lat_min_x <= r_min_x;
        r_lat_max_x <= r_max_x;
        r_lat_min_y <= r_min_y;
        r_lat_max_y <= r_max_y;
      end
      r_min_x <= {X_W{1'b1}};
      r_max_x <= {X_W{1'b0}};
      r_min_y <= {Y_W{1'b1}};
      r_max_y <= {Y_W{1'b0}};
    end else if (w_fg) begin
      if (w_px < r_min_x) r_min_x <= w_px;
      if (w_px > r_max_x) r_max_x <= w_px;
      if (w_py < r_min_y) r_min_y <= w_py;
      if (w_py > r_max_y) r_max_y <= w_py;
    end
  end

  // Bounding-box outputs, zero when no target was found.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bbox_min_x <= {X_W{1'b0}};
      bbox_max_x <= {X_W{1'b0}};
      bbox_min_y <= {Y_W{1'b0}};
      bbox_max_y <= {Y_W{1'b0}};
    end else if (r_state == OUTPUT) begin
      if (r_lat_found) begin
        bbox_min_x <= r_lat_min_x;
        bbox_max_x <= r_lat_max_x;
        bbox_min_y <= r_lat_min_y;
        bbox_max_y <= r_lat_max_y;
      end else begin
        bbox_min_x <= {X_W{1'b0}};
        bbox_max_x <= {X_W{1'b0}};
        bbox_min_y <= {Y_W{1'b0}};
        bbox_max_y <= {Y_W{1'b0}};
      end
    end
  end
`else
  assign bbox_min_x = {X_W{1'b0}};
  assign bbox_max_x = {X_W{1'b0}};
  assign bbox_min_y = {Y_W{1'b0}};
  assign bbox_max_y = {Y_W{1'b0}};
`endif

endmodule

// File: doc/binary_target_locator.md
Name: binary_target_locator

Overview:
- Consumes the thresholded binary pixel stream (vsync/href/32-bit all-ones or all-zeros words) produced by the binarization stage.
- Accumulates foreground pixel count and coordinate sums per frame, then divides to give the target centroid in pixels.
- Result goes to the arm-control logic as one valid pulse per frame.

Parameters:
- IMG_WIDTH, 640, active pixels per line.
- IMG_HEIGHT, 480, active lines per frame.
- X_W, 10, width of x coordinate (must satisfy 2^X_W >= IMG_WIDTH).
- Y_W, 9, width of y coordinate.
- CNT_W, 19, pixel counter width (must satisfy 2^CNT_W > IMG_WIDTH*IMG_HEIGHT).
- SUM_W, 29, coordinate-sum width (CNT_W + X_W).
- MIN_PIXELS, 64, minimum foreground count for a valid target.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset; asynchronous, active-high.
- vsync_in  in  1  frame sync; high = vertical blanking.
- href_in  in  1  line valid; one pixel per clk while high.
- binary_data_in  in  32  binary pixel word.
- result_valid  out  1  one-cycle pulse; outputs below are valid from this cycle.
- target_found  out  1  1 when pixel_count >= MIN_PIXELS.
- target_x  out  X_W  centroid x.
- target_y  out  Y_W  centroid y.
- pixel_count  out  CNT_W  foreground pixels in frame.
- frame_drop  out  1  one-cycle pulse when a frame result is discarded.
- bbox_min_x/bbox_max_x  out  X_W each, bbox_min_y/bbox_max_y  out  Y_W each  bounding box (see Optional Feature).

Behaviour:
- Reset: all outputs 0; counters and accumulators 0; bbox min registers set to all-ones, max registers to 0; state ACCUM.
- Foreground pixel means href_in=1, vsync_in=0, and |binary_data_in=1.
- x counter: 0 at start of each href-high run. Increments per href cycle and saturates at IMG_WIDTH. Pixels with x >= IMG_WIDTH are ignored.
- y counter: increments on each href falling edge, saturating at IMG_HEIGHT; lines with y >= IMG_HEIGHT are ignored. Cleared on frame end.
- For each foreground pixel: count += 1, sum_x += x, sum_y += y. Sum widths are never exceeded by construction.
- Frame end is the cycle where vsync_in=1 and its registered copy is 0 (rising edge).
- State machine:
  - ACCUM -> DIVIDE on frame end: latch count/sums, clear accumulators and y in the same cycle.
  - DIVIDE: two parallel dividers compute sum_x/count and sum_y/count. Each takes exactly SUM_W cycles, restoring, 1 quotient bit per cycle. -> OUTPUT when both report done.
  - OUTPUT: drive the result registers, pulse result_valid for 1 cycle -> ACCUM.
- If latched count < MIN_PIXELS:
  - dividers are not started; DIVIDE is skipped and the FSM goes directly to OUTPUT.
  - target_found=0, target_x=target_y=0, pixel_count = latched count.
  - Latency is 2 cycles from frame end to result_valid.
- Normal latency: frame end at cycle 0 -> dividers start cycle 1 -> result_valid at cycle SUM_W+2.
- Output registers hold their values until the next result_valid. Quotient bits above X_W/Y_W are truncated; they are always 0 by construction.
- Accumulation of the next frame runs concurrently with DIVIDE/OUTPUT.
- Frame end while state != ACCUM: that frame's accumulators are cleared and discarded, frame_drop pulses, and the in-flight division is unaffected.
- Simultaneous frame end and OUTPUT cycle counts as state != ACCUM, so the frame is dropped.
- Reset mid-division aborts immediately to reset values with no result_valid.

Optional Feature:
- Macro: BINARY_LOCATOR_BBOX_EN.
- Defined:
  - per foreground pixel, min/max x/y registers are updated.
  - Values are latched at frame end and presented on the bbox_* outputs with result_valid.
  - If target_found=0, all bbox outputs are 0.
- Undefined: no bbox logic is built, and all bbox_* outputs are constant 0.

Decomposition:
- Shared package (vision_pkg): IMG_WIDTH/IMG_HEIGHT defaults, width constants X_W/Y_W/CNT_W/SUM_W, and the FSM state encoding (ACCUM=0, DIVIDE=1, OUTPUT=2).
- One sub-module, seq_divider (parameterised widths; start/done handshake; done pulses 1 cycle after the SUM_W-th iteration). It is instantiated twice.

Test Plan:
- 640x480 frame, 10x10 white block x=100..109, y=200..209 -> pixel_count=100, target_x=104, target_y=204, target_found=1, result_valid exactly SUM_W+2 cycles after vsync rise.
- 5x5 block (25 px) -> target_found=0, x=y=0, pixel_count=25, result_valid 2 cycles after vsync rise.
- All-black frame, then all-white frame -> count 0/found 0, then count 307200, target_x=319, target_y=239.
- Second vsync rise injected 10 cycles after the first -> one frame_drop pulse; the first frame's result is still correct and unchanged.
- rst asserted in DIVIDE cycle 5 -> all outputs 0 immediately, no result_valid; the next full frame gives a correct result.
- With BINARY_LOCATOR_BBOX_EN, block from first test -> bbox 100/109/200/209. Without the macro -> bbox outputs 0.
